// File: rtl/mux2_stream_arbiter_if.sv
// mux2_stream_arbiter_if: two valid/ready requesters, one registered output stream, arbiter status
interface mux2_stream_arbiter_if #(parameter int WIDTH = 8);
  logic in0_valid, in0_ready, in0_last;
  logic in1_valid, in1_ready, in1_last;
  logic [WIDTH-1:0] in0_data, in1_data, out_data;
  logic out_valid, out_ready, out_last, out_src, sel, busy;
  modport master (
    output in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_last, out_src, sel, busy
  );
  modport slave (
    input  in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_last, out_src, sel, busy
  );
endinterface

// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter: round-robin 2:1 stream mux with optional packet lock and registered output
module mux2_stream_arbiter #(
  parameter int WIDTH    = 8,
  parameter bit LOCK_PKT = 1'b1
) (
  input logic clk,
  input logic rst,
  mux2_stream_arbiter_if.slave bus
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state_q, state_d;
  logic last_grant_q, last_grant_d, sel_q, sel_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, out_src_q, out_src_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic load_en, has_grant, grant, acc, acc_last, pkt_open;
  always_comb begin
    load_en = !out_valid_q || bus.out_ready;
    has_grant = state_q == LOCK || bus.in0_valid || bus.in1_valid;
    // In LOCK the held select is the owner; otherwise a tie goes against the last winner
    grant = state_q == LOCK ? sel_q : (bus.in0_valid && bus.in1_valid) ? !last_grant_q : bus.in1_valid;
    sel_d = (has_grant && load_en) ? grant : sel_q;
    bus.in0_ready = load_en && !grant && bus.in0_valid;
    bus.in1_ready = load_en && grant && bus.in1_valid;
    acc = bus.in0_ready || bus.in1_ready;
    acc_last = grant ? bus.in1_last : bus.in0_last;
    pkt_open = LOCK_PKT && !acc_last;
    out_valid_d = acc || (out_valid_q && !bus.out_ready);
    out_data_d = acc ? (sel_d ? bus.in1_data : bus.in0_data) : out_data_q;
    out_last_d = acc ? acc_last : out_last_q;
    out_src_d = acc ? grant : out_src_q;
    state_d = acc ? (pkt_open ? LOCK : IDLE) : state_q;
    last_grant_d = (acc && !pkt_open) ? grant : last_grant_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      sel_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_src_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      sel_q <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_src_q <= out_src_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_last = out_last_q;
  assign bus.out_src = out_src_q;
  assign bus.sel = sel_d;
  assign bus.busy = state_q == LOCK;
endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Shares one 2:1 data mux between two valid/ready streaming requesters.
- Round-robin arbitration drives the mux select; the chosen beat goes into a single registered output stage.
- Optional packet lock holds the grant from the first beat of a packet through its last beat.
- Sits in front of any single-consumer datapath fed by two producers.

Parameters:
WIDTH, 8, data bits per beat
LOCK_PKT, 1, 1 = hold grant until a beat with last=1 is accepted; 0 = re-arbitrate every beat

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in0_valid  input  1  requester 0 beat valid
in0_ready  output  1  requester 0 beat accepted this cycle
in0_data  input  WIDTH  requester 0 data
in0_last  input  1  requester 0 end of packet
in1_valid  input  1  requester 1 beat valid
in1_ready  output  1  requester 1 beat accepted this cycle
in1_data  input  WIDTH  requester 1 data
in1_last  input  1  requester 1 end of packet
out_valid  output  1  registered output beat valid
out_ready  input  1  downstream accepts output beat
out_data  output  WIDTH  registered output data
out_last  output  1  registered output last
out_src  output  1  index of the requester that supplied the current output beat
sel  output  1  current mux select (grant)
busy  output  1  high while in LOCK state

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_last=0, out_src=0, sel=0, busy=0, state=IDLE, rr pointer last_grant=1 (input 0 wins the first tie).
- Reset mid-packet drops the lock and discards any held output beat; there is no recovery of the partial packet.
- load_en = !out_valid || out_ready. No input is ready when load_en=0.
- State IDLE, grant decision (combinational):
  - both valid -> grant = ~last_grant;
  - only one valid -> that input;
  - none valid -> no grant, sel holds its previous value.
- State LOCK: grant is fixed to the locked input; the other input is ignored even if valid.
- inN_ready = load_en && grant==N && inN_valid. At most one ready is high per cycle. Ready may depend on valid; sources must not derive valid from ready.
- Accept (inN_valid && inN_ready), registered on the next edge:
  - out_data, out_last and out_src take input N's values; out_valid=1.
  - Latency is 1 cycle from accept to out_valid.
- Output handshake:
  - out_valid && out_ready with no new accept -> out_valid=0 next cycle.
  - Simultaneous drain and accept -> the new beat replaces the old one; throughput is 1 beat/cycle.
- Pointer and state transitions, LOCK_PKT=1:
  - IDLE: accept with last=0 -> LOCK, busy=1, sel held.
  - IDLE: accept with last=1 -> stay IDLE, last_grant=N.
  - LOCK: accept with last=1 -> IDLE, busy=0, last_grant=N.
  - LOCK: the locked input deasserting valid mid-packet keeps LOCK; the arbiter waits indefinitely.
- Pointer and state transitions, LOCK_PKT=0:
  - The FSM never leaves IDLE; busy stays 0.
  - last_grant=N after every accept.
  - last is passed through unchanged.
- sel equals the grant whenever a grant exists; otherwise it holds. This drives the shared mux so that out_data = sel ? in1_data : in0_data at load.
- Stall: out_valid=1 && out_ready=0 -> all outputs hold, both readies are 0, state and pointer are unchanged.

Test Plan:
- Reset then single stream: rst 2 cycles, in0 sends 0x11,0x22(last), out_ready=1 -> out_data 0x11 then 0x22 one cycle after each accept, out_src=0, no bubbles.
- Tie fairness: LOCK_PKT=0, both valid every cycle with single-beat last=1 packets, in0=0xA0.., in1=0xB0.. -> accepts alternate 0,1,0,1 starting with 0; out_src toggles each cycle.
- Packet lock: LOCK_PKT=1, in0 4-beat packet (last on beat 4) with in1 valid throughout -> all 4 in0 beats contiguous, busy=1 beats 1–3, then in1 granted next.
- Backpressure: out_ready=0 for 3 cycles mid-stream -> out_valid/out_data hold, in0_ready=in1_ready=0; on release, no beat is lost or duplicated.
- Lock with gap: in1 packet beat 1 (last=0), in1_valid low 5 cycles while in0 valid -> in0 never ready, sel=1 held; in1 resumes and its last beat returns the FSM to IDLE.
- Reset mid-packet: rst asserted during LOCK with out_valid=1 -> next cycle out_valid=0, busy=0, sel=0; the next tie grants in0.
